pipe_ctrl_fsm: RTL and testbench

//  Pipeline sequencer for the 3-stage core (IF | DE/EX | MW).
//  - Turns branch/jump flush, multi-cycle data-memory handshakes, interrupts and bus timeouts

---
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl_fsm.sv | 168 ++++++++++++++++
 tb/tb_pipe_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control interface: request/handshake inputs from the core and
// data memory, stall/flush/trap controls and status back out.
interface pipe_ctrl_if;
  logic       flush_req;
  logic       dmem_req;
  logic       dmem_ready;
  logic       irq;
  logic       irq_en;
  logic       stall_if;
  logic       stall_de;
  logic       flush_de;
  logic       dmem_valid;
  logic       trap_take;
  logic       bus_err;
  logic [2:0] state_o;

  // Core / memory side: drives requests, observes controls
  modport master (
    output flush_req, dmem_req, dmem_ready, irq, irq_en,
    input  stall_if, stall_de, flush_de, dmem_valid, trap_take, bus_err, state_o
  );

  // Sequencer side: observes requests, drives controls
  modport slave (
    input  flush_req, dmem_req, dmem_ready, irq, irq_en,
    output stall_if, stall_de, flush_de, dmem_valid, trap_take, bus_err, state_o
  );
endinterface

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline sequencer for the 3-stage core. Converts branch flushes,
// multi-cycle data-memory accesses, interrupts and bus timeouts into
// per-cycle stall/flush/trap controls. State and counter are registered;
// controls are decoded combinationally from state and current inputs.
module pipe_ctrl_fsm #(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input logic         clk,
  input logic         rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_BOOT     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_TRAP     = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_TO    = CNT_W'(MEM_TIMEOUT);

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, next_cnt_s;
  logic             bus_err_r;
  logic             stall_if_s, stall_de_s, flush_de_s, dmem_valid_s, trap_take_s;

  // Saturating increment: the shared counter never wraps back to zero
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // State, counter and sticky bus-error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_BOOT;
      cnt_r     <= CNT_ZERO;
      bus_err_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      if (next_state_s == ST_HALT) begin
        bus_err_r <= 1'b1;
      end else begin
        bus_err_r <= bus_err_r;
      end
    end
  end

  // Next-state and counter decode
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      ST_BOOT: begin
        if (cnt_r == BOOT_LAST) begin
          next_state_s = ST_RUN;
          next_cnt_s   = CNT_ZERO;
        end else begin
          next_cnt_s = sat_inc(cnt_r);
        end
      end
      ST_RUN: begin
        next_cnt_s = CNT_ZERO;
        if (bus.dmem_req) begin
          if (!bus.dmem_ready) begin
            next_state_s = ST_MEM_WAIT;
            next_cnt_s   = CNT_ONE;
          end else begin
            next_state_s = ST_RUN;
          end
        end else if (bus.flush_req) begin
          // irq is a level; it is simply re-sampled once the flush is done
          next_state_s = ST_RUN;
        end else if (bus.irq && bus.irq_en) begin
          next_state_s = ST_TRAP;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          next_state_s = ST_RUN;
          next_cnt_s   = CNT_ZERO;
        end else if ((MEM_TIMEOUT != 0) && (cnt_r == MEM_TO)) begin
          next_state_s = ST_HALT;
          next_cnt_s   = sat_inc(cnt_r);
        end else begin
          next_cnt_s = sat_inc(cnt_r);
        end
      end
      ST_TRAP: begin
        next_state_s = ST_RUN;
        next_cnt_s   = CNT_ZERO;
      end
      ST_HALT: begin
        next_state_s = ST_HALT;
      end
      default: begin
        next_state_s = ST_BOOT;
        next_cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Control outputs from current state and inputs
  always_comb begin
    stall_if_s   = 1'b0;
    stall_de_s   = 1'b0;
    flush_de_s   = 1'b0;
    dmem_valid_s = 1'b0;
    trap_take_s  = 1'b0;
    case (state_r)
      ST_BOOT: begin
        stall_if_s = 1'b1;
        flush_de_s = 1'b1;
      end
      ST_RUN: begin
        if (bus.dmem_req) begin
          dmem_valid_s = 1'b1;
          stall_if_s   = !bus.dmem_ready;
          stall_de_s   = !bus.dmem_ready;
        end else if (bus.flush_req) begin
          flush_de_s = 1'b1;
        end else begin
          flush_de_s = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        // Stalls release in the completing cycle so the instruction advances
        dmem_valid_s = 1'b1;
        stall_if_s   = !bus.dmem_ready;
        stall_de_s   = !bus.dmem_ready;
      end
      ST_TRAP: begin
        trap_take_s = 1'b1;
        flush_de_s  = 1'b1;
      end
      ST_HALT: begin
        stall_if_s = 1'b1;
        stall_de_s = 1'b1;
      end
      default: begin
        stall_if_s = 1'b1;
        flush_de_s = 1'b1;
      end
    endcase
  end

  assign bus.stall_if   = stall_if_s;
  assign bus.stall_de   = stall_de_s;
  assign bus.flush_de   = flush_de_s;
  assign bus.dmem_valid = dmem_valid_s;
  assign bus.trap_take  = trap_take_s;
  assign bus.bus_err    = bus_err_r;
  assign bus.state_o    = state_r;

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Testbench for pipe_ctrl_fsm: directed vector table, hand-written
// timeout / async-reset sequences, and randomized traffic against a
// behavioural model.
module tb_pipe_ctrl_fsm;

  localparam int BOOT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [2:0] last_state;

  pipe_ctrl_if ifc ();

  pipe_ctrl_fsm #(.BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal stimulus guard: one DE/EX instruction cannot both branch and access memory
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(ifc.flush_req && ifc.dmem_req)) else $error("illegal flush_req with dmem_req");
    end
  end

  // Expected-output packing: {stall_if, stall_de, flush_de, dmem_valid, trap_take, bus_err, state[2:0]}
  typedef struct {
    logic       fr, dr, rdy, iq, ie;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [15];

  // Behavioural model state
  int m_boot;
  bit m_wait;
  int m_waited;
  bit m_trap;
  bit m_halt;

  function automatic logic [8:0] dut_out();
    return {ifc.stall_if, ifc.stall_de, ifc.flush_de, ifc.dmem_valid,
            ifc.trap_take, ifc.bus_err, ifc.state_o};
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = dut_out();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (sif sde fde val tt err st)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic fr, dr, rdy, iq, ie);
    ifc.flush_req  = fr;
    ifc.dmem_req   = dr;
    ifc.dmem_ready = rdy;
    ifc.irq        = iq;
    ifc.irq_en     = ie;
  endtask

  task automatic model_reset();
    m_boot   = BOOT_CYCLES;
    m_wait   = 1'b0;
    m_waited = 0;
    m_trap   = 1'b0;
    m_halt   = 1'b0;
  endtask

  // One cycle of the behavioural model: expected outputs now, then advance
  task automatic model_cycle(input bit fr, dr, rdy, iq, ie, output logic [8:0] exp);
    bit sif, sde, fde, val, tt, err;
    logic [2:0] st;
    sif = 1'b0; sde = 1'b0; fde = 1'b0; val = 1'b0; tt = 1'b0;
    err = m_halt;
    if (m_boot > 0) begin
      sif = 1'b1; fde = 1'b1; st = 3'd0;
      m_boot--;
    end else if (m_halt) begin
      sif = 1'b1; sde = 1'b1; st = 3'd4;
    end else if (m_trap) begin
      tt = 1'b1; fde = 1'b1; st = 3'd3;
      m_trap = 1'b0;
    end else if (m_wait) begin
      st = 3'd2; val = 1'b1;
      m_waited++;
      if (rdy) begin
        m_wait = 1'b0;
      end else begin
        sif = 1'b1; sde = 1'b1;
        if (MEM_TIMEOUT != 0 && m_waited == MEM_TIMEOUT) begin
          m_halt = 1'b1;
          m_wait = 1'b0;
        end
      end
    end else begin
      st = 3'd1;
      if (dr) begin
        val = 1'b1;
        if (!rdy) begin
          sif = 1'b1; sde = 1'b1;
          m_wait = 1'b1; m_waited = 0;
        end
      end else if (fr) begin
        fde = 1'b1;
      end else if (iq && ie) begin
        m_trap = 1'b1;
      end
    end
    exp = {sif, sde, fde, val, tt, err, st};
  endtask

  // Called at posedge+1; returns at the following posedge+1
  task automatic run_cycle(input bit fr, dr, rdy, iq, ie, input string name);
    logic [8:0] exp;
    model_cycle(fr, dr, rdy, iq, ie, exp);
    drive(fr, dr, rdy, iq, ie);
    @(negedge clk);
    last_state = ifc.state_o;
    check(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic hw_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("reset_state", 9'b101000000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int waits;
    bit fr, dr, rdy, iq, ie;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b101000000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b101000000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b000000001};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'b000100001};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b110100001};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b110100010};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'b110100010};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 9'b000100010};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b000000001};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b001010011};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'b001000001};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b000000001};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'b001010011};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9'b000000001};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b001000001};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Directed vector table: boot, zero-wait and waited access, irq in wait, flush vs irq
    hw_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].fr, tbl[i].dr, tbl[i].rdy, tbl[i].iq, tbl[i].ie);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp);
      @(posedge clk);
      #1;
    end

    // Memory timeout: HALT after MEM_TIMEOUT wait cycles, sticky bus_err, reset clears
    hw_reset();
    repeat (2) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "to_boot");
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "to_enter");
    waits = 0;
    for (int k = 0; k < 40; k++) begin
      run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "to_wait");
      if (last_state == 3'd2) waits++;
    end
    check_int("timeout_wait_cycles", waits, MEM_TIMEOUT);
    @(negedge clk);
    check("halt_sticky", 9'b110001100);
    #2;
    rst_n = 1'b0;
    #1;
    check("halt_reset_clear", 9'b101000000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_halt_boot");
    check_int("post_halt_run_state", int'(last_state), 1);

    // Async reset in the middle of a memory wait
    hw_reset();
    repeat (2) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mw_boot");
    run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "mw_enter");
    #3;
    check("mw_before_reset", 9'b110100010);
    rst_n = 1'b0;
    #1;
    check("mw_async_reset", 9'b101000000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mw_reboot");

    // Randomized traffic against the behavioural model
    hw_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 249) begin
        hw_reset();
      end
      dr  = ($urandom_range(0, 2) == 0);
      fr  = !dr && ($urandom_range(0, 3) == 0);
      if ((i / 250) % 4 == 3) begin
        rdy = ($urandom_range(0, 15) == 0);
      end else begin
        rdy = $urandom_range(0, 1);
      end
      iq  = $urandom_range(0, 1);
      ie  = $urandom_range(0, 1);
      run_cycle(fr, dr, rdy, iq, ie, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
